// File: rtl/sb_pkg.sv
// Shared types and sizing for the store buffer: the entry layout, the default
// geometry, and the word-granularity address compare used by forwarding.
package sb_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   localparam int SB_PTR_W = $clog2(SB_DEPTH);
   localparam int SB_CNT_W = SB_PTR_W + 1;

   // The entry layout is fixed by SB_AW/SB_DW, so the top's AW/DW must stay
   // equal to these values.
   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

   // Loads and stores hit the same entry when they address the same 32-bit word.
   function automatic logic word_match(input logic [SB_AW-1:0] a,
                                       input logic [SB_AW-1:0] b);
      return a[SB_AW-1:2] == b[SB_AW-1:2];
   endfunction

endpackage

// File: rtl/sb_forward.sv
// Load forwarding search: finds the youngest valid buffered store whose word
// address matches the lookup address and returns its data.
module sb_forward
   import sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic [DEPTH-1:0]      valid,
   input  logic [PTR_W-1:0]      tail,
   input  logic [SB_AW-1:0]      addr,
   output logic                  hit,
   output logic [SB_DW-1:0]      data
);

   logic [PTR_W-1:0] idx;

   // Walk from oldest (tail-DEPTH) to youngest (tail-1); later matches overwrite
   // earlier ones, so the youngest match wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail - PTR_W'(k);
         if (valid[idx] && word_match(entries[idx].addr, addr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory. Stores are
// queued and drained in order whenever memory is ready; loads are forwarded
// from the youngest matching buffered store, otherwise served from memory.
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_we,
   input  logic [AW-1:0]            cpu_adr,
   input  logic [DW-1:0]            cpu_wd,
   output logic [DW-1:0]            cpu_rd,
   output logic                     stall,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_wa,
   output logic [DW-1:0]            mem_wd,
   input  logic                     mem_ready,
   output logic [AW-1:0]            mem_ra,
   input  logic [DW-1:0]            mem_rd,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t [DEPTH-1:0] entries;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [DEPTH-1:0]      valid;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  fwd_hit;
   logic [DW-1:0]         fwd_data;
   logic [PTR_W-1:0]      offset;

   // A pop that frees a slot does not admit a store in the same cycle; the
   // stalled store enters on the following cycle.
   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign stall  = cpu_we && full;
   assign push   = cpu_we && !full;
   assign mem_we = !empty;
   assign pop    = mem_we && mem_ready;
   assign mem_wa = entries[head].addr;
   assign mem_wd = entries[head].data;
   assign mem_ra = cpu_adr;

   // Pointers and occupancy; reset discards any pending stores at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   // Entry storage needs no reset: validity comes only from head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[tail].addr <= cpu_adr;
         entries[tail].data <= cpu_wd;
      end
   end

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      valid  = '0;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset   = PTR_W'(i) - head;
         valid[i] = ({1'b0, offset} < count);
      end
   end

   sb_forward #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_forward (
      .entries (entries),
      .valid   (valid),
      .tail    (tail),
      .addr    (cpu_adr),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   // Forwarded data takes priority over memory read data.
   always_comb begin
      cpu_rd = fwd_hit ? fwd_data : mem_rd;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed stimulus with a drain-order scoreboard
// checked by an independent monitor, plus directed checks on status and loads.
module tb_store_buffer;

   logic        clk;
   logic        reset;
   logic        cpu_we;
   logic [31:0] cpu_adr;
   logic [31:0] cpu_wd;
   logic [31:0] cpu_rd;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_wa;
   logic [31:0] mem_wd;
   logic        mem_ready;
   logic [31:0] mem_ra;
   logic [31:0] mem_rd;
   logic        empty;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t expq[$];

   store_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_adr   (cpu_adr),
      .cpu_wd    (cpu_wd),
      .cpu_rd    (cpu_rd),
      .stall     (stall),
      .mem_we    (mem_we),
      .mem_wa    (mem_wa),
      .mem_wd    (mem_wd),
      .mem_ready (mem_ready),
      .mem_ra    (mem_ra),
      .mem_rd    (mem_rd),
      .empty     (empty),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                                input logic ready, input logic [31:0] rd);
      cpu_we    = we;
      cpu_adr   = adr;
      cpu_wd    = wd;
      mem_ready = ready;
      mem_rd    = rd;
   endtask

   task automatic expectDrain(input logic [31:0] adr, input logic [31:0] wd);
      wr_t w;
      w.addr = adr;
      w.data = wd;
      expq.push_back(w);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted drain write must match the oldest expected store.
   always @(negedge clk) begin
      if (reset && mem_we && mem_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_unexpected: got write %h<-%h expected none", mem_wa, mem_wd);
         end else begin
            wr_t w;
            w = expq.pop_front();
            checkOutput("drain_addr", mem_wa, w.addr);
            checkOutput("drain_data", mem_wd, w.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      applyStimulus(1'b1, 32'h100, 32'h0, 1'b1, 32'h1234);
      #3;
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("rst_empty",  {31'b0, empty},  32'd1);
      checkOutput("rst_count",  {29'b0, count},  32'd0);
      checkOutput("rst_stall",  {31'b0, stall},  32'd0);
      checkOutput("rst_cpu_rd", cpu_rd,          32'h1234);
      checkOutput("rst_mem_ra", mem_ra,          32'h100);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      cycle();
      reset = 1'b1;
      cycle();

      // Reset mid-stream with three stores pending.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'(i + 1), 1'b0, 32'h0);
         expectDrain(32'h200 + 32'(4 * i), 32'(i + 1));
         cycle();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("pre_rst_count", {29'b0, count}, 32'd3);
      cycle();
      #2;
      reset = 1'b0;
      expq.delete();
      #1;
      checkOutput("midrst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("midrst_count",  {29'b0, count},  32'd0);
      checkOutput("midrst_empty",  {31'b0, empty},  32'd1);
      cycle();
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) cycle();
      @(negedge clk);
      checkOutput("post_rst_empty", {31'b0, empty}, 32'd1);
      cycle();

      // Single store held by memory back-pressure, then drained.
      applyStimulus(1'b1, 32'h100, 32'hAAAA0001, 1'b0, 32'h0);
      expectDrain(32'h100, 32'hAAAA0001);
      cycle();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_mem_we", {31'b0, mem_we}, 32'd1);
         checkOutput("hold_mem_wa", mem_wa, 32'h100);
         checkOutput("hold_mem_wd", mem_wd, 32'hAAAA0001);
         cycle();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("single_count1", {29'b0, count}, 32'd1);
      cycle();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("single_count0", {29'b0, count}, 32'd0);
      checkOutput("single_empty",  {31'b0, empty}, 32'd1);
      cycle();

      // Fill, stall, pop without admitting, then admit next cycle.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'h0);
         expectDrain(32'h10 + 32'(4 * i), 32'h1000 + 32'(i));
         cycle();
      end
      applyStimulus(1'b1, 32'h20, 32'h2020, 1'b0, 32'h0);
      expectDrain(32'h20, 32'h2020);
      @(negedge clk);
      checkOutput("full_count", {29'b0, count}, 32'd4);
      checkOutput("full_stall", {31'b0, stall}, 32'd1);
      cycle();
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("popcyc_stall", {31'b0, stall}, 32'd1);
      cycle();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("after_pop_count", {29'b0, count}, 32'd3);
      checkOutput("after_pop_stall", {31'b0, stall}, 32'd0);
      cycle();
      cpu_we = 1'b0;
      @(negedge clk);
      checkOutput("admit_count", {29'b0, count}, 32'd4);
      cycle();
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("fill_drained", {31'b0, empty}, 32'd1);
      cycle();

      // Forwarding from the youngest matching store.
      applyStimulus(1'b1, 32'h40, 32'h1, 1'b0, 32'h0);
      expectDrain(32'h40, 32'h1);
      cycle();
      applyStimulus(1'b1, 32'h40, 32'h2, 1'b0, 32'h0);
      expectDrain(32'h40, 32'h2);
      cycle();
      applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 32'hDEAD);
      @(negedge clk);
      checkOutput("fwd_0x40", cpu_rd, 32'h2);
      cycle();
      cpu_adr = 32'h42;
      @(negedge clk);
      checkOutput("fwd_0x42", cpu_rd, 32'h2);
      cycle();
      cpu_adr = 32'h44;
      @(negedge clk);
      checkOutput("fwd_miss", cpu_rd, 32'hDEAD);
      cycle();
      mem_ready = 1'b1;
      cycle();
      cycle();
      mem_ready = 1'b0;

      // Head entry still forwards in its pop cycle.
      applyStimulus(1'b1, 32'h50, 32'h5, 1'b0, 32'hDEAD);
      expectDrain(32'h50, 32'h5);
      cycle();
      applyStimulus(1'b0, 32'h50, 32'h0, 1'b1, 32'hDEAD);
      @(negedge clk);
      checkOutput("fwd_pop_cycle", cpu_rd, 32'h5);
      cycle();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("fwd_after_pop", cpu_rd, 32'hDEAD);
      cycle();

      // A store is not forwarded to itself in its own cycle.
      applyStimulus(1'b1, 32'h60, 32'h9, 1'b0, 32'hBEEF);
      expectDrain(32'h60, 32'h9);
      @(negedge clk);
      checkOutput("fwd_self", cpu_rd, 32'hBEEF);
      cycle();
      cpu_we = 1'b0;
      @(negedge clk);
      checkOutput("fwd_next", cpu_rd, 32'h9);
      cycle();
      mem_ready = 1'b1;
      cycle();
      mem_ready = 1'b0;

      // Simultaneous push and pop at count 2 across pointer wrap.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 32'h2A0 + 32'(4 * i), 32'h500 + 32'(i), 1'b0, 32'h0);
         expectDrain(32'h2A0 + 32'(4 * i), 32'h500 + 32'(i));
         cycle();
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'h600 + 32'(i), 1'b1, 32'h0);
         expectDrain(32'h300 + 32'(4 * i), 32'h600 + 32'(i));
         @(negedge clk);
         checkOutput("pushpop_count", {29'b0, count}, 32'd2);
         cycle();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      cycle();
      cycle();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("final_empty", {31'b0, empty}, 32'd1);
      checkOutput("sb_leftover", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data port and dmem.
- Core stores are queued in a small FIFO and committed later, while the core continues.
- Entries drain to memory in order whenever memory signals ready.
- Core loads are forwarded from the youngest matching buffered store; otherwise they are served from memory.

Parameters:
DEPTH, 4, number of buffered stores; power of two, minimum 2
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous reset, active-low
cpu_we  input  1  core store request (MemWrite)
cpu_adr  input  AW  core data address (ALUResult), used for both stores and loads
cpu_wd  input  DW  core store data (WriteData)
cpu_rd  output  DW  load data returned to core (ReadData)
stall  output  1  core must hold its current store; asserted when cpu_we is high and the buffer is full
mem_we  output  1  drain-write valid; high whenever the buffer is non-empty
mem_wa  output  AW  drain-write address (head entry)
mem_wd  output  DW  drain-write data (head entry)
mem_ready  input  1  memory accepts the drain write this cycle
mem_ra  output  AW  memory read address; equals cpu_adr combinationally
mem_rd  input  DW  memory read data
empty  output  1  no entries pending (fence/idle indication)
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State:
  - DEPTH entries of {addr, data}.
  - Head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter, range 0..DEPTH.
- Reset (reset low, asynchronous):
  - Pointers and count go to 0; entry contents are don't-care.
  - Outputs while in reset: mem_we=0, empty=1, count=0, stall=0.
  - cpu_rd = mem_rd, because there is no forwarding when empty.
- Reset mid-drain: pending stores are discarded. mem_we drops with reset, not at the next edge.
- push = cpu_we && !full:
  - Writes {cpu_adr, cpu_wd} at tail; tail advances.
  - The entry is visible to forwarding and to drain from the next cycle.
- pop = mem_we && mem_ready:
  - Head advances at the edge.
  - mem_wa and mem_wd present the head entry combinationally from the registered entry.
  - They remain stable while mem_ready is low.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- Full (count==DEPTH):
  - stall = cpu_we && full, combinational.
  - A pop in the same cycle does NOT admit a push; the store enters the following cycle.
- Empty: mem_we=0, and mem_ready is ignored.
- Forwarding (combinational, no added latency):
  - Compare cpu_adr[AW-1:2] against every valid entry's addr[AW-1:2] (word granularity).
  - On any match, cpu_rd = data of the youngest matching entry, i.e. the one closest to tail.
  - Otherwise cpu_rd = mem_rd.
- Head entry during a pop cycle: it is still valid for forwarding in that cycle.
- A store presented in the current cycle is not forwarded to itself.
- Ordering: drain order equals push order. No coalescing; duplicate addresses produce separate writes.
- Validity: an entry is valid iff its index lies in [head, head+count) modulo DEPTH.

Decomposition:
- Shared package sb_pkg:
  - sb_entry_t struct {addr, data}.
  - Pointer-width and count-width localparams derived from DEPTH.
- One sub-module, sb_forward:
  - Takes the entry array, valid vector, tail pointer and lookup address.
  - Returns hit and data via a youngest-first priority search.
  - Kept separate so it can be tested in isolation.
- FIFO storage and pointers stay in store_buffer.

Test Plan:
- Reset low mid-stream with 3 entries pending -> mem_we=0, count=0, empty=1 immediately; after release, no stale writes appear.
- Push 0x100<-0xAAAA0001 with mem_ready=0 for 3 cycles -> mem_we=1, mem_wa=0x100, mem_wd=0xAAAA0001 held stable; raise mem_ready -> count 1->0, empty=1 the next cycle.
- With mem_ready=0, push 4 stores to 0x10,0x14,0x18,0x1C, then assert cpu_we with 0x20 -> count=4, stall=1; pulse mem_ready one cycle -> 0x10 drains; 0x20 is accepted the following cycle (not the pop cycle); drain order 0x14,0x18,0x1C,0x20.
- Forwarding, mem_ready=0:
  - Push 0x40<-1, then 0x40<-2.
  - Load 0x40 -> cpu_rd=2.
  - Load 0x42 -> cpu_rd=2 (word match).
  - Load 0x44 with mem_rd=0xDEAD -> cpu_rd=0xDEAD.
- Simultaneous push/pop at count=2 -> count stays 2, tail and head each advance by one, and the pointers wrap correctly after 2*DEPTH operations.
